// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: four-digit multiplexed hex display scanner.
// Optional per-digit blink is built when HEX_BLINK_EN is defined.
module hex_display_scheduler #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [3:0]  hex_en,
  output logic [7:0]  hex_seg,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIGIT_CYCLES);

  localparam logic [CW-1:0] CNT_MAX =
    CW'(DIGIT_CYCLES - 1);

  localparam logic [CW-1:0] GUARD_LAST =
    CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  blink;
  } disp_t;

  typedef enum logic [1:0] {
    S_OFF,
    S_GUARD,
    S_ON
  } state_t;

  // A zero guard width skips the blanking phase entirely.
  localparam state_t SLOT_START =
    (GUARD_CYCLES == 0) ? S_ON : S_GUARD;

  localparam disp_t RESET_DISP = '{
    value: 16'h0000,
    blank: 4'b1111,
    dp:    4'b0000,
    blink: 4'b0000
  };

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    digit;
  logic [1:0]    digit_n;

  disp_t act;
  disp_t pend;
  logic  pend_valid;

  logic       frame_end;
  logic       swap;
  logic [3:0] blink_mask;
  logic [3:0] nib;
  logic [7:0] glyph;
  logic       dark;

  function automatic logic [7:0] glyph_of(
    input logic [3:0] n
  );
    logic [7:0] g;
    g = 8'h00;
    unique case (n)
      4'h0: g = 8'hFC;
      4'h1: g = 8'h60;
      4'h2: g = 8'hDA;
      4'h3: g = 8'hF2;
      4'h4: g = 8'h66;
      4'h5: g = 8'hB6;
      4'h6: g = 8'hBE;
      4'h7: g = 8'hE0;
      4'h8: g = 8'hFE;
      4'h9: g = 8'hF6;
      4'hA: g = 8'hEE;
      4'hB: g = 8'h3E;
      4'hC: g = 8'h9C;
      4'hD: g = 8'h7A;
      4'hE: g = 8'h9E;
      4'hF: g = 8'h8E;
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  // Last lit clock of digit 3; suppressed when scanning is being dropped.
  assign frame_end = enable
                   && (state == S_ON)
                   && (digit == 2'd3)
                   && (cnt == CNT_MAX);

  // Active word may only be replaced at a frame boundary or while dark.
  assign swap = pend_valid
              && (frame_end || (state == S_OFF));

  assign load_ready = ~pend_valid;
  assign frame_tick = frame_end;

  // Scan state, slot counter and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_OFF;
      cnt   <= '0;
      digit <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      digit <= digit_n;
    end
  end

  // Next-state logic for the OFF / GUARD / ON scan sequence.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    digit_n = digit;
    if (!enable) begin
      state_n = S_OFF;
      cnt_n   = '0;
      digit_n = 2'd0;
    end else begin
      unique case (state)
        S_OFF: begin
          state_n = SLOT_START;
          cnt_n   = '0;
          digit_n = 2'd0;
        end
        S_GUARD: begin
          cnt_n = cnt + CW'(1);
          if (cnt == GUARD_LAST) begin
            state_n = S_ON;
          end
        end
        S_ON: begin
          if (cnt == CNT_MAX) begin
            cnt_n   = '0;
            digit_n = digit + 2'd1;
            state_n = SLOT_START;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = S_OFF;
          cnt_n   = '0;
          digit_n = 2'd0;
        end
      endcase
    end
  end

  // Pending/active double buffer with valid/ready load handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act        <= RESET_DISP;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else if (swap) begin
      act        <= pend;
      pend_valid <= 1'b0;
    end else if (load_valid && !pend_valid) begin
      pend       <= '{
        value: value_in,
        blank: blank_in,
        dp:    dp_in,
        blink: blink_in
      };
      pend_valid <= 1'b1;
    end
  end

`ifdef HEX_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [BW-1:0] BLINK_LAST =
    BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Blink phase flips every BLINK_FRAMES frames; restarts lit when dark.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (state == S_OFF) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign blink_mask = blink_phase ? 4'b0000 : act.blink;
`else
  logic unused_blink;

  assign unused_blink = (^act.blink)
                      ^ (BLINK_FRAMES > 0);
  assign blink_mask   = 4'b0000;
`endif

  assign nib   = act.value[{digit, 2'b00} +: 4];
  assign glyph = glyph_of(nib);
  assign dark  = act.blank[digit] | blink_mask[digit];

  // Drive the lit digit only in ON and only when not blanked.
  always_comb begin
    hex_en  = 4'b0000;
    hex_seg = 8'h00;
    if ((state == S_ON) && !dark) begin
      hex_en  = 4'b0001 << digit;
      hex_seg = glyph | {7'b0, act.dp[digit]};
    end
  end

endmodule
